// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and the access-legality check for the
// memory-access pipeline stage.
package mem_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Write-back select encodings
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // True when a memory op must not reach the bus: undefined size/sign
    // encodings, unsigned variants on a store, or a misaligned half/word.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lsb);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_LB:  bad = 1'b0;
            F3_LH:  bad = addr_lsb[0];
            F3_LW:  bad = (addr_lsb != 2'b00);
            F3_LBU: bad = is_store;
            F3_LHU: bad = is_store | addr_lsb[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a returned memory word and
// sign- or zero-extends it according to the load funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0 before extension
    assign shifted = rdata_i >> {addr_i, 3'b000};

    // Extend the selected lane to a full word
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data_o = {24'h000000, shifted[7:0]};
            F3_LHU:  data_o = {16'h0000, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues byte-enabled loads/stores to data
// memory with a ready handshake, aligns load data and registers the result
// into the MEM/WB pipeline register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [DATA_WIDTH-1:0]     ex_pc_plus_4,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_reg_write,
    input  logic [1:0]                ex_wb_sel,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [2:0]                ex_funct3,
    output logic                      stall_o,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_ready,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic [DATA_WIDTH-1:0]     wb_alu_result,
    output logic [DATA_WIDTH-1:0]     wb_mem_data,
    output logic [DATA_WIDTH-1:0]     wb_pc_plus_4,
    output logic [1:0]                wb_sel_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      wb_reg_write,
    output logic                      mem_fault_o
);

    state_e                    state_q, state_d;

    // Access registers, held stable for the whole ACCESS phase
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      rw_q, rw_d;
    logic [1:0]                sel_q, sel_d;
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;
    logic [DATA_WIDTH-1:0]     pc4_q, pc4_d;

    // MEM/WB pipeline register
    logic                      wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0]     wb_alu_q, wb_alu_d;
    logic [DATA_WIDTH-1:0]     wb_mem_q, wb_mem_d;
    logic [DATA_WIDTH-1:0]     wb_pc4_q, wb_pc4_d;
    logic [1:0]                wb_sel_q, wb_sel_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                      wb_rw_q, wb_rw_d;
    logic                      fault_q, fault_d;

    logic                      accept;
    logic                      is_mem;
    logic                      is_store;
    logic                      fault;
    logic [3:0]                store_be;
    logic [DATA_WIDTH-1:0]     store_wdata;
    logic [DATA_WIDTH-1:0]     load_data;

    assign accept   = ex_valid & ~flush;
    assign is_mem   = ex_mem_read | ex_mem_write;
    // A request with both read and write set behaves as a store
    assign is_store = ex_mem_write;
    assign fault    = access_fault(is_store, ex_funct3, ex_alu_result[1:0]);

    // Store lane enables and lane-replicated write data
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << ex_alu_result[1:0];
                store_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << ex_alu_result[1:0];
                store_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = ex_store_data;
            end
        endcase
    end

    mem_load_align u_align (
        .funct3_i (funct3_q),
        .addr_i   (addr_q[1:0]),
        .rdata_i  (dmem_rdata),
        .data_o   (load_data)
    );

    // Next-state logic for the FSM, access registers and MEM/WB register
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        sel_d      = sel_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        wb_valid_d = 1'b0;
        wb_alu_d   = wb_alu_q;
        wb_mem_d   = wb_mem_q;
        wb_pc4_d   = wb_pc4_q;
        wb_sel_d   = wb_sel_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        fault_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem || fault) begin
                        // Completes immediately; a faulting access never
                        // reaches the bus and must not write a register
                        wb_valid_d = 1'b1;
                        wb_alu_d   = ex_alu_result;
                        wb_pc4_d   = ex_pc_plus_4;
                        wb_sel_d   = ex_wb_sel;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = is_mem ? 1'b0 : ex_reg_write;
                        fault_d    = is_mem;
                    end else begin
                        state_d  = ACCESS;
                        addr_d   = ex_alu_result[ADDR_WIDTH-1:0];
                        be_d     = is_store ? store_be : 4'b1111;
                        wdata_d  = is_store ? store_wdata : '0;
                        we_d     = is_store;
                        funct3_d = ex_funct3;
                        rd_d     = ex_rd;
                        rw_d     = ex_reg_write;
                        sel_d    = ex_wb_sel;
                        alu_d    = ex_alu_result;
                        pc4_d    = ex_pc_plus_4;
                    end
                end
            end
            ACCESS: begin
                // flush is deliberately not looked at: the access is committed
                if (dmem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_alu_d   = alu_q;
                    wb_pc4_d   = pc4_q;
                    wb_sel_d   = sel_q;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = we_q ? 1'b0 : rw_q;
                    wb_mem_d   = we_q ? '0 : load_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            sel_q      <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_pc4_q   <= '0;
            wb_sel_q   <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            sel_q      <= sel_d;
            alu_q      <= alu_d;
            pc4_q      <= pc4_d;
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_pc4_q   <= wb_pc4_d;
            wb_sel_q   <= wb_sel_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            fault_q    <= fault_d;
        end
    end

    assign stall_o       = (state_q == ACCESS);
    assign dmem_req      = (state_q == ACCESS);
    assign dmem_we       = we_q;
    assign dmem_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;

    assign wb_valid      = wb_valid_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_mem_data   = wb_mem_q;
    assign wb_pc_plus_4  = wb_pc4_q;
    assign wb_sel_o      = wb_sel_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_rw_q;
    assign mem_fault_o   = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads, stores,
// faults, asynchronous reset, flush and back-to-back issue.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc_plus_4;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [1:0]  ex_wb_sel;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        stall_o;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_pc_plus_4;
    logic [1:0]  wb_sel_o;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_fault_o;

    int n_checks;
    int n_fail;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_pc_plus_4  (ex_pc_plus_4),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_wb_sel     (ex_wb_sel),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .stall_o       (stall_o),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_pc_plus_4  (wb_pc_plus_4),
        .wb_sel_o      (wb_sel_o),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .mem_fault_o   (mem_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                          input logic [1:0] sel, input logic mr, input logic mw,
                          input logic [2:0] f3);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_pc_plus_4  = pc4;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_wb_sel     = sel;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_funct3     = f3;
    endtask

    task automatic clr_ex;
        set_ex(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", dmem_req); end
        n_checks++; if (mem_fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b want 0", mem_fault_o); end
        n_checks++; if (wb_alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_wb_alu: got %h want 0", wb_alu_result); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
        step;
        rst_n = 1'b1;
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_alu_op;
        set_ex(1'b1, 32'h1234, 32'h0, 32'h104, 5'd5, 1'b1, WB_ALU, 1'b0, 1'b0, 3'b000);
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall_pre: got %0b want 0", stall_o); end
        step;
        clr_ex;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_alu_result !== 32'h1234) begin n_fail++; $display("FAIL alu_result: got %h want 00001234", wb_alu_result); end
        n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", wb_rd); end
        n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_reg_write: got %0b want 1", wb_reg_write); end
        n_checks++; if (wb_pc_plus_4 !== 32'h104) begin n_fail++; $display("FAIL alu_pc4: got %h want 00000104", wb_pc_plus_4); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall_post: got %0b want 0", stall_o); end
        step;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %0b want 0", wb_valid); end
        $display("txn alu: result=%h rd=%0d", wb_alu_result, wb_rd);
    endtask

    task automatic test_load_byte;
        set_ex(1'b1, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LB);
        step;
        clr_ex;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FFFFFF;
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL lb_req: got %0b want 1", dmem_req); end
        n_checks++; if (dmem_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", dmem_addr); end
        n_checks++; if (dmem_be !== 4'b1111) begin n_fail++; $display("FAIL lb_be: got %b want 1111", dmem_be); end
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %0b want 0", dmem_we); end
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lb_stall: got %0b want 1", stall_o); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wb_early: got %0b want 0", wb_valid); end
        step;
        dmem_ready = 1'b0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lb_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_mem_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", wb_mem_data); end
        n_checks++; if (wb_rd !== 5'd7) begin n_fail++; $display("FAIL lb_rd: got %0d want 7", wb_rd); end
        n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL lb_reg_write: got %0b want 1", wb_reg_write); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lb_stall_post: got %0b want 0", stall_o); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lb_req_post: got %0b want 0", dmem_req); end
        $display("txn lb: addr=00001003 data=%h", wb_mem_data);

        set_ex(1'b1, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LBU);
        step;
        clr_ex;
        dmem_ready = 1'b1;
        step;
        dmem_ready = 1'b0;
        n_checks++; if (wb_mem_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", wb_mem_data); end
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lbu_wb_valid: got %0b want 1", wb_valid); end
        $display("txn lbu: addr=00001003 data=%h", wb_mem_data);
    endtask

    task automatic test_store;
        int stall_cnt;
        stall_cnt = 0;
        set_ex(1'b1, 32'h2002, 32'hAAAABEEF, 32'h0, 5'd3, 1'b1, WB_ALU, 1'b0, 1'b1, F3_SH);
        step;
        clr_ex;
        for (int c = 0; c < 3; c++) begin
            dmem_ready = (c == 2);
            if (stall_o === 1'b1) stall_cnt++;
            if (c == 0) begin
                n_checks++; if (dmem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", dmem_be); end
                n_checks++; if (dmem_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", dmem_wdata); end
                n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %0b want 1", dmem_we); end
                n_checks++; if (dmem_addr !== 32'h2000) begin n_fail++; $display("FAIL sh_addr: got %h want 00002000", dmem_addr); end
            end
            step;
        end
        dmem_ready = 1'b0;
        n_checks++; if (stall_cnt != 3) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d want 3", stall_cnt); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL sh_stall_post: got %0b want 0", stall_o); end
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL sh_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL sh_reg_write: got %0b want 0", wb_reg_write); end
        n_checks++; if (wb_mem_data !== 32'h0) begin n_fail++; $display("FAIL sh_mem_data: got %h want 00000000", wb_mem_data); end
        $display("txn sh: addr=00002002 stall_cycles=%0d", stall_cnt);

        set_ex(1'b1, 32'h6001, 32'h12345678, 32'h0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, F3_SB);
        step;
        clr_ex;
        dmem_ready = 1'b1;
        n_checks++; if (dmem_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", dmem_be); end
        n_checks++; if (dmem_wdata !== 32'h78787878) begin n_fail++; $display("FAIL sb_wdata: got %h want 78787878", dmem_wdata); end
        step;
        dmem_ready = 1'b0;
        $display("txn sb: addr=00006001 be=0010");
    endtask

    task automatic test_fault;
        set_ex(1'b1, 32'h3001, 32'h0, 32'h0, 5'd4, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LW);
        step;
        clr_ex;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_fault_req: got %0b want 0", dmem_req); end
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lw_fault_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL lw_fault_reg_write: got %0b want 0", wb_reg_write); end
        n_checks++; if (mem_fault_o !== 1'b1) begin n_fail++; $display("FAIL lw_fault_pulse: got %0b want 1", mem_fault_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lw_fault_stall: got %0b want 0", stall_o); end
        step;
        n_checks++; if (mem_fault_o !== 1'b0) begin n_fail++; $display("FAIL lw_fault_one_cycle: got %0b want 0", mem_fault_o); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_fault_req_late: got %0b want 0", dmem_req); end
        $display("txn lw misaligned: addr=00003001 faulted");

        // funct3 011 on an aligned store is illegal
        set_ex(1'b1, 32'h3000, 32'h0, 32'h0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b1, 3'b011);
        step;
        clr_ex;
        n_checks++; if (mem_fault_o !== 1'b1) begin n_fail++; $display("FAIL st011_fault: got %0b want 1", mem_fault_o); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL st011_req: got %0b want 0", dmem_req); end
        step;
        $display("txn store funct3=011: faulted");
    endtask

    task automatic test_async_reset;
        set_ex(1'b1, 32'h7000, 32'h0, 32'h0, 5'd6, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LW);
        step;
        clr_ex;
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %0b want 1", dmem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %0b want 0", dmem_req); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall: got %0b want 0", stall_o); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_wb_valid: got %0b want 0", wb_valid); end
        step;
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 2; c++) begin
            step;
            n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_late_req: got %0b want 0", dmem_req); end
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_wb_valid: got %0b want 0", wb_valid); end
            n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_stall: got %0b want 0", stall_o); end
        end
        dmem_ready = 1'b0;
        $display("txn async reset during access: late ready ignored");
    endtask

    task automatic test_flush;
        set_ex(1'b1, 32'h4000, 32'h0, 32'h0, 5'd8, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LW);
        flush = 1'b1;
        step;
        clr_ex;
        flush = 1'b0;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_req: got %0b want 0", dmem_req); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_wb_valid: got %0b want 0", wb_valid); end
        $display("txn flush in idle: dropped");

        set_ex(1'b1, 32'h4002, 32'h0, 32'h0, 5'd8, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LH);
        step;
        clr_ex;
        flush = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80011234;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_access_stall: got %0b want 1", stall_o); end
        step;
        flush = 1'b0;
        dmem_ready = 1'b0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL flush_access_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_mem_data !== 32'hFFFF8001) begin n_fail++; $display("FAIL flush_access_lh_data: got %h want ffff8001", wb_mem_data); end
        n_checks++; if (wb_rd !== 5'd8) begin n_fail++; $display("FAIL flush_access_rd: got %0d want 8", wb_rd); end
        $display("txn flush during access: lh data=%h", wb_mem_data);
    endtask

    task automatic test_back_to_back;
        set_ex(1'b1, 32'h5000, 32'h0, 32'h0, 5'd10, 1'b1, WB_MEM, 1'b1, 1'b0, F3_LW);
        step;
        // Next instruction presented and held while stalled
        set_ex(1'b1, 32'h77, 32'h0, 32'h0, 5'd9, 1'b1, WB_ALU, 1'b0, 1'b0, 3'b000);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %0b want 1", stall_o); end
        step;
        dmem_ready = 1'b0;
        n_checks++; if (wb_mem_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_lw_data: got %h want deadbeef", wb_mem_data); end
        n_checks++; if (wb_rd !== 5'd10) begin n_fail++; $display("FAIL b2b_lw_rd: got %0d want 10", wb_rd); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_stall: got %0b want 0", stall_o); end
        step;
        set_ex(1'b1, 32'h22, 32'h0, 32'h0, 5'd2, 1'b1, WB_PC4, 1'b0, 1'b0, 3'b000);
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_alu_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_alu_result !== 32'h77) begin n_fail++; $display("FAIL b2b_alu_result: got %h want 00000077", wb_alu_result); end
        n_checks++; if (wb_rd !== 5'd9) begin n_fail++; $display("FAIL b2b_alu_rd: got %0d want 9", wb_rd); end
        step;
        clr_ex;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_alu2_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_alu_result !== 32'h22) begin n_fail++; $display("FAIL b2b_alu2_result: got %h want 00000022", wb_alu_result); end
        n_checks++; if (wb_sel_o !== WB_PC4) begin n_fail++; $display("FAIL b2b_alu2_sel: got %b want 10", wb_sel_o); end
        step;
        $display("txn back-to-back: lw then two alu ops");
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        flush      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        clr_ex;
        test_reset;
        test_alu_op;
        test_load_byte;
        test_store;
        test_fault;
        test_async_reset;
        test_flush;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
